// File: rtl/cpc_fifo_slave_ctrl.sv
// Slave-side sequencer for the SN74HCT40105 FIFO pair: turns tx/rx byte streams into
// timed SI / SOB / WNR pin sequences and owns the direction of the shared sd bus.
module cpc_fifo_slave_ctrl #(
   parameter int SETUP_CYCLES   = 2,
   parameter int PULSE_CYCLES   = 3,
   parameter int RECOVER_CYCLES = 4,
   parameter int TURN_CYCLES    = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic       fifo_slave_dir,
   input  logic       fifo_slave_dor,
   output logic       slave_fifo_si,
   output logic       slave_fifo_sob,
   output logic       slave_fifo_wnr,
   input  logic [7:0] sd_in,
   output logic [7:0] sd_out,
   output logic       sd_oe
);

   localparam int MAX_A   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
   localparam int MAX_B   = (RECOVER_CYCLES > TURN_CYCLES) ? RECOVER_CYCLES : TURN_CYCLES;
   localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVER_CYCLES - 1);
   localparam logic [CNT_W-1:0] TURN_LAST    = CNT_W'(TURN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      W_TURN_ON  = 4'd1,
      W_SETUP    = 4'd2,
      W_PULSE    = 4'd3,
      W_RECOVER  = 4'd4,
      W_TURN_OFF = 4'd5,
      R_SETTLE   = 4'd6,
      R_PULSE    = 4'd7,
      R_RECOVER  = 4'd8
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic             dir_meta_r, dir_s, dor_meta_r, dor_s;
   logic             si_r, si_nxt_s;
   logic             sob_r, sob_nxt_s;
   logic             wnr_r, wnr_nxt_s;
   logic             sd_oe_r, sd_oe_nxt_s;
   logic [7:0]       sd_out_r, sd_out_nxt_s;
   logic             tx_ready_r, tx_ready_nxt_s;
   logic [7:0]       rx_data_r, rx_data_nxt_s;
   logic             rx_valid_r, rx_valid_nxt_s;
   logic             last_write_r, last_write_nxt_s;
   logic             wr_elig_s, rd_elig_s;

   assign wr_elig_s = tx_valid & dir_s;
   assign rd_elig_s = dor_s & ~rx_valid_r;

   // Two-flop synchronisers for the asynchronous FIFO ready flags.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         dir_meta_r <= 1'b0;
         dir_s      <= 1'b0;
         dor_meta_r <= 1'b0;
         dor_s      <= 1'b0;
      end else begin
         dir_meta_r <= fifo_slave_dir;
         dir_s      <= dir_meta_r;
         dor_meta_r <= fifo_slave_dor;
         dor_s      <= dor_meta_r;
      end
   end

   // Next-state and next-pin logic; every pin change happens on a state transition.
   always_comb begin
      state_nxt_s      = state_r;
      cnt_nxt_s        = cnt_r + CNT_ONE;
      si_nxt_s         = si_r;
      sob_nxt_s        = sob_r;
      wnr_nxt_s        = wnr_r;
      sd_oe_nxt_s      = sd_oe_r;
      sd_out_nxt_s     = sd_out_r;
      tx_ready_nxt_s   = 1'b0;
      rx_data_nxt_s    = rx_data_r;
      rx_valid_nxt_s   = rx_valid_r & ~rx_ready;
      last_write_nxt_s = last_write_r;
      case (state_r)
         IDLE: begin
            cnt_nxt_s = CNT_ZERO;
            // Round robin: on a tie the type opposite to the last completed transfer wins.
            if (rd_elig_s && (!wr_elig_s || last_write_r)) begin
               state_nxt_s = R_SETTLE;
            end else if (wr_elig_s) begin
               state_nxt_s    = W_TURN_ON;
               wnr_nxt_s      = 1'b1;
               sd_out_nxt_s   = tx_data;
               tx_ready_nxt_s = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         W_TURN_ON: begin
            if (cnt_r == TURN_LAST) begin
               state_nxt_s = W_SETUP;
               cnt_nxt_s   = CNT_ZERO;
               sd_oe_nxt_s = 1'b1;
            end else begin
               state_nxt_s = W_TURN_ON;
            end
         end
         W_SETUP: begin
            if (cnt_r == SETUP_LAST) begin
               state_nxt_s = W_PULSE;
               cnt_nxt_s   = CNT_ZERO;
               si_nxt_s    = 1'b1;
            end else begin
               state_nxt_s = W_SETUP;
            end
         end
         W_PULSE: begin
            if (cnt_r == PULSE_LAST) begin
               state_nxt_s = W_RECOVER;
               cnt_nxt_s   = CNT_ZERO;
               si_nxt_s    = 1'b0;
            end else begin
               state_nxt_s = W_PULSE;
            end
         end
         W_RECOVER: begin
            if (cnt_r == RECOVER_LAST) begin
               cnt_nxt_s        = CNT_ZERO;
               last_write_nxt_s = 1'b1;
               // Stay in write mode only while no read is waiting.
               if (wr_elig_s && !rd_elig_s) begin
                  state_nxt_s    = W_SETUP;
                  sd_out_nxt_s   = tx_data;
                  tx_ready_nxt_s = 1'b1;
               end else begin
                  state_nxt_s = W_TURN_OFF;
                  sd_oe_nxt_s = 1'b0;
               end
            end else begin
               state_nxt_s = W_RECOVER;
            end
         end
         W_TURN_OFF: begin
            if (cnt_r == TURN_LAST) begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = CNT_ZERO;
               wnr_nxt_s   = 1'b0;
            end else begin
               state_nxt_s = W_TURN_OFF;
            end
         end
         R_SETTLE: begin
            if (cnt_r == SETUP_LAST) begin
               state_nxt_s   = R_PULSE;
               cnt_nxt_s     = CNT_ZERO;
               rx_data_nxt_s = sd_in;
               sob_nxt_s     = 1'b0;
            end else begin
               state_nxt_s = R_SETTLE;
            end
         end
         R_PULSE: begin
            if (cnt_r == PULSE_LAST) begin
               state_nxt_s    = R_RECOVER;
               cnt_nxt_s      = CNT_ZERO;
               sob_nxt_s      = 1'b1;
               rx_valid_nxt_s = 1'b1;
            end else begin
               state_nxt_s = R_PULSE;
            end
         end
         R_RECOVER: begin
            if (cnt_r == RECOVER_LAST) begin
               state_nxt_s      = IDLE;
               cnt_nxt_s        = CNT_ZERO;
               last_write_nxt_s = 1'b0;
            end else begin
               state_nxt_s = R_RECOVER;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = CNT_ZERO;
            si_nxt_s    = 1'b0;
            sob_nxt_s   = 1'b1;
            wnr_nxt_s   = 1'b0;
            sd_oe_nxt_s = 1'b0;
         end
      endcase
   end

   // State, counter and registered pin outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r      <= IDLE;
         cnt_r        <= CNT_ZERO;
         si_r         <= 1'b0;
         sob_r        <= 1'b1;
         wnr_r        <= 1'b0;
         sd_oe_r      <= 1'b0;
         sd_out_r     <= 8'h00;
         tx_ready_r   <= 1'b0;
         rx_data_r    <= 8'h00;
         rx_valid_r   <= 1'b0;
         last_write_r <= 1'b1;
      end else begin
         state_r      <= state_nxt_s;
         cnt_r        <= cnt_nxt_s;
         si_r         <= si_nxt_s;
         sob_r        <= sob_nxt_s;
         wnr_r        <= wnr_nxt_s;
         sd_oe_r      <= sd_oe_nxt_s;
         sd_out_r     <= sd_out_nxt_s;
         tx_ready_r   <= tx_ready_nxt_s;
         rx_data_r    <= rx_data_nxt_s;
         rx_valid_r   <= rx_valid_nxt_s;
         last_write_r <= last_write_nxt_s;
      end
   end

   assign slave_fifo_si  = si_r;
   assign slave_fifo_sob = sob_r;
   assign slave_fifo_wnr = wnr_r;
   assign sd_oe          = sd_oe_r;
   assign sd_out         = sd_out_r;
   assign tx_ready       = tx_ready_r;
   assign rx_data        = rx_data_r;
   assign rx_valid       = rx_valid_r;

endmodule

// File: tb/tb_cpc_fifo_slave_ctrl.sv
// Scoreboard bench for cpc_fifo_slave_ctrl: a pin monitor pops expected transfer kinds and
// bytes as SI/SOB pulses appear and checks pulse widths, setup and bus turnaround timing.
module tb_cpc_fifo_slave_ctrl;

   localparam int SETUP   = 2;
   localparam int PULSE   = 3;
   localparam int RECOVER = 4;
   localparam int TURN    = 2;
   localparam logic [7:0] KW = 8'h57;
   localparam logic [7:0] KR = 8'h52;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       dir, dor;
   logic       si, sob, wnr;
   logic [7:0] sd_in, sd_out;
   logic       sd_oe;

   cpc_fifo_slave_ctrl #(
      .SETUP_CYCLES(SETUP), .PULSE_CYCLES(PULSE),
      .RECOVER_CYCLES(RECOVER), .TURN_CYCLES(TURN)
   ) dut (
      .CLK(CLK), .RESET(RESET),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .fifo_slave_dir(dir), .fifo_slave_dor(dor),
      .slave_fifo_si(si), .slave_fifo_sob(sob), .slave_fifo_wnr(wnr),
      .sd_in(sd_in), .sd_out(sd_out), .sd_oe(sd_oe)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
   endtask

   logic [7:0] tx_q[$];
   logic [7:0] exp_wr[$];
   logic [7:0] exp_rd[$];
   logic [7:0] exp_kind[$];

   task automatic push_tx(input logic [7:0] b);
      tx_q.push_back(b);
      exp_wr.push_back(b);
   endtask

   // Producer: holds tx_valid/tx_data until the tx_ready handshake, then advances.
   initial begin
      logic hs;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      forever begin
         @(negedge CLK);
         hs = tx_valid && tx_ready;
         @(posedge CLK);
         #1;
         if (hs && tx_q.size() > 0) void'(tx_q.pop_front());
         if (tx_q.size() > 0) begin
            tx_valid = 1'b1;
            tx_data  = tx_q[0];
         end else begin
            tx_valid = 1'b0;
         end
      end
   end

   int   cyc = 0, xfer_cnt = 0, tx_ready_cnt = 0, wnr_fall_cnt = 0, sob_fall_cnt = 0;
   int   wnr_chg_c = 0, oe_chg_c = 0, sdout_chg_c = 0, si_rise_c = 0, sob_fall_c = 0;
   int   last_si_rise_c = 0;
   logic wnr_fell_since = 1'b1;
   logic p_si = 1'b0, p_sob = 1'b1, p_wnr = 1'b0, p_oe = 1'b0, p_rst = 1'b1;
   logic [7:0] p_sdout = 8'h00;

   // Pin monitor: scoreboard pops and timing checks, sampled on the falling edge.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge CLK);
         cyc++;
         if (tx_ready) tx_ready_cnt++;
         if (RESET || p_rst) begin
            wnr_chg_c = cyc; oe_chg_c = cyc; sdout_chg_c = cyc;
            wnr_fell_since = 1'b1;
         end else begin
            if (sd_out !== p_sdout) sdout_chg_c = cyc;
            if (wnr !== p_wnr) begin
               check_eq("wnr_chg_oe", {30'd0, p_oe, sd_oe}, 32'd0);
               if (!wnr) begin
                  check_eq("oe_to_wnr", cyc - oe_chg_c, TURN);
                  wnr_fall_cnt++;
                  wnr_fell_since = 1'b1;
               end
               wnr_chg_c = cyc;
            end
            if (sd_oe !== p_oe) begin
               check_eq("oe_chg_wnr", {31'd0, wnr}, 32'd1);
               if (sd_oe) check_eq("wnr_to_oe", cyc - wnr_chg_c, TURN);
               oe_chg_c = cyc;
            end
            if (si && !p_si) begin
               xfer_cnt++;
               e = (exp_kind.size() > 0) ? exp_kind.pop_front() : 8'hxx;
               check_eq("kind_w", {24'd0, KW}, {24'd0, e});
               e = (exp_wr.size() > 0) ? exp_wr.pop_front() : 8'hxx;
               check_eq("wr_data", {24'd0, sd_out}, {24'd0, e});
               check_eq("wr_setup", {31'd0, (cyc - sdout_chg_c) >= SETUP}, 32'd1);
               check_eq("si_bus", {30'd0, wnr, sd_oe}, 32'd3);
               if (!wnr_fell_since && last_si_rise_c != 0)
                  check_eq("si_period", cyc - last_si_rise_c, SETUP + PULSE + RECOVER);
               last_si_rise_c = cyc;
               si_rise_c = cyc;
               wnr_fell_since = 1'b0;
            end
            if (!si && p_si) check_eq("si_width", cyc - si_rise_c, PULSE);
            if (!sob && p_sob) begin
               xfer_cnt++;
               sob_fall_cnt++;
               e = (exp_kind.size() > 0) ? exp_kind.pop_front() : 8'hxx;
               check_eq("kind_r", {24'd0, KR}, {24'd0, e});
               check_eq("rd_bus", {30'd0, wnr, sd_oe}, 32'd0);
               sob_fall_c = cyc;
            end
            if (sob && !p_sob) begin
               check_eq("sob_width", cyc - sob_fall_c, PULSE);
               check_eq("rxv_at_sob", {31'd0, rx_valid}, 32'd1);
               e = (exp_rd.size() > 0) ? exp_rd.pop_front() : 8'hxx;
               check_eq("rd_data", {24'd0, rx_data}, {24'd0, e});
            end
         end
         p_si = si; p_sob = sob; p_wnr = wnr; p_oe = sd_oe; p_sdout = sd_out; p_rst = RESET;
      end
   end

   task automatic wait_xfers(input int target, input string tag);
      for (int i = 0; i < 400 && xfer_cnt < target; i++) @(negedge CLK);
      check_eq(tag, {31'd0, xfer_cnt >= target}, 32'd1);
   endtask

   initial begin
      int   base, t0, f0, s0;
      logic bad;
      RESET = 1'b1; dir = 1'b0; dor = 1'b0; sd_in = 8'h00; rx_ready = 1'b0;
      repeat (3) @(negedge CLK);
      check_eq("rst_pins", {28'd0, si, sob, wnr, sd_oe}, 32'h4);
      check_eq("rst_sdout", {24'd0, sd_out}, 32'd0);
      check_eq("rst_hs", {30'd0, tx_ready, rx_valid}, 32'd0);
      check_eq("rst_rxdata", {24'd0, rx_data}, 32'd0);
      @(posedge CLK); #1 RESET = 1'b0;

      // Idle with a byte pending but dir=0: nothing may move.
      exp_kind.push_back(KW);
      push_tx(8'hA5);
      bad = 1'b0;
      repeat (50) begin
         @(negedge CLK);
         if ({si, sob, wnr, sd_oe} !== 4'b0100) bad = 1'b1;
      end
      check_eq("idle_pins", {31'd0, bad}, 32'd0);
      check_eq("idle_txready", tx_ready_cnt, 0);

      // Single write of 0xA5.
      dir = 1'b1;
      base = xfer_cnt;
      wait_xfers(base + 1, "wr1_wait");
      repeat (20) @(negedge CLK);
      check_eq("wr1_txready", tx_ready_cnt, 1);
      check_eq("wr1_end", {30'd0, wnr, sd_oe}, 32'd0);

      // Back-to-back writes keep wnr high.
      t0 = tx_ready_cnt; f0 = wnr_fall_cnt; base = xfer_cnt;
      repeat (3) exp_kind.push_back(KW);
      push_tx(8'h01); push_tx(8'h02); push_tx(8'h03);
      wait_xfers(base + 3, "b2b_wait");
      check_eq("b2b_wnr_held", wnr_fall_cnt - f0, 0);
      repeat (20) @(negedge CLK);
      check_eq("b2b_txready", tx_ready_cnt - t0, 3);

      // Read of 0x3C held while the consumer is not ready.
      s0 = sob_fall_cnt; base = xfer_cnt;
      sd_in = 8'h3C;
      exp_rd.push_back(8'h3C);
      exp_kind.push_back(KR);
      dor = 1'b1;
      wait_xfers(base + 1, "rd_wait");
      repeat (40) @(negedge CLK);
      check_eq("rd_single_sob", sob_fall_cnt - s0, 1);
      check_eq("rd_held_valid", {31'd0, rx_valid}, 32'd1);
      check_eq("rd_held_data", {24'd0, rx_data}, 32'h3C);
      dor = 1'b0;
      repeat (4) @(negedge CLK);
      @(posedge CLK); #1 rx_ready = 1'b1;
      @(posedge CLK); #1 rx_ready = 1'b0;
      @(negedge CLK);
      check_eq("rd_taken", {31'd0, rx_valid}, 32'd0);

      // Contention after reset: read, write, read, write.
      @(posedge CLK); #1 RESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      rx_ready = 1'b1;
      sd_in = 8'h81;
      exp_rd.push_back(8'h81); exp_rd.push_back(8'h7E);
      exp_kind.push_back(KR); exp_kind.push_back(KW);
      exp_kind.push_back(KR); exp_kind.push_back(KW);
      dor = 1'b1;
      base = xfer_cnt;
      repeat (3) @(posedge CLK);
      #1;
      push_tx(8'h96); push_tx(8'h69);
      wait_xfers(base + 1, "rr_wait1");
      sd_in = 8'h7E;
      wait_xfers(base + 4, "rr_wait4");
      dor = 1'b0;
      repeat (30) @(negedge CLK);
      check_eq("rr_drain", exp_kind.size() + exp_wr.size() + exp_rd.size(), 0);
      check_eq("rr_end", {30'd0, wnr, sd_oe}, 32'd0);

      // Reset in the middle of an SI pulse, then a clean write of 0x55.
      exp_kind.push_back(KW);
      push_tx(8'h77);
      for (int i = 0; i < 100 && si !== 1'b1; i++) @(negedge CLK);
      check_eq("pulse_seen", {31'd0, si}, 32'd1);
      RESET = 1'b1;
      @(negedge CLK);
      check_eq("rst_in_pulse", {28'd0, si, sob, wnr, sd_oe}, 32'h4);
      @(posedge CLK); #1 RESET = 1'b0;
      exp_kind.push_back(KW);
      push_tx(8'h55);
      base = xfer_cnt;
      wait_xfers(base + 1, "post_rst_wait");
      repeat (20) @(negedge CLK);
      check_eq("post_rst_end", {30'd0, wnr, sd_oe}, 32'd0);
      check_eq("final_drain", exp_kind.size() + exp_wr.size() + exp_rd.size() + tx_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
